// File: rtl/lc3_perf_pkg.sv
// Shared definitions for the LC3 performance-counter MMIO block:
// register offsets, CTRL/STATUS bit positions and handshake states.
package lc3_perf_pkg;

  localparam logic [2:0] ADDR_CYC_LO = 3'd0;
  localparam logic [2:0] ADDR_CYC_HI = 3'd1;
  localparam logic [2:0] ADDR_INS_LO = 3'd2;
  localparam logic [2:0] ADDR_INS_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_CLR_BIT     = 1;
  localparam int STAT_HALT_BIT    = 0;
  localparam int STAT_TIMEOUT_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear and a hold (freeze) input.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !hold && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/perf_counter_mmio.sv
// Cycle / retired-instruction counters with halt and watchdog flags,
// read over a 16-bit request/response handshake with coherent 32-bit snapshots.
module perf_counter_mmio
  import lc3_perf_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 10000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_v,
  input  logic        isHalt,
  input  logic        req_v,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_v,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_data,
  output logic        halted,
  output logic        timeout
);

  state_t           state;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ins;
  logic [15:0]      snap_cyc_hi;
  logic [CNT_W-1:0] snap_ins;
  logic [15:0]      rsp_q;
  logic [15:0]      rd_data;
  logic             en;
  logic             active;
  logic             accept;
  logic             wr_ctrl;
  logic             clr;
  logic             wdog_hit;
  logic             wdata_unused;

  assign active   = en & ~halted & ~timeout;
  assign accept   = (state == IDLE) & req_v;
  assign wr_ctrl  = accept & req_we & (req_addr == ADDR_CTRL);
  assign clr      = wr_ctrl & req_wdata[CTRL_CLR_BIT];
  assign wdog_hit = active & (cyc == CNT_W'(WDOG_LIMIT - 1));
  assign wdata_unused = ^req_wdata[15:2];

  // Once inactive both counters freeze; cyc therefore parks at WDOG_LIMIT.
  perf_sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .hold  (~active),
    .inc   (1'b1),
    .count (cyc)
  );

  perf_sat_counter #(.CNT_W(CNT_W)) u_ins (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .hold  (~active),
    .inc   (W_v),
    .count (ins)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else if (clr) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (active && isHalt) halted  <= 1'b1;
      if (wdog_hit)         timeout <= 1'b1;
    end
  end

  // A clear-only write leaves en alone so software can restart counting in one access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b1;
    end else if (wr_ctrl && !req_wdata[CTRL_CLR_BIT]) begin
      en <= req_wdata[CTRL_EN_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_cyc_hi <= '0;
      snap_ins    <= '0;
    end else if (clr) begin
      snap_cyc_hi <= '0;
      snap_ins    <= '0;
    end else if (accept && !req_we && (req_addr == ADDR_CYC_LO)) begin
      snap_cyc_hi <= cyc[31:16];
      snap_ins    <= ins;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      ADDR_CYC_LO: rd_data = cyc[15:0];
      ADDR_CYC_HI: rd_data = snap_cyc_hi;
      ADDR_INS_LO: rd_data = snap_ins[15:0];
      ADDR_INS_HI: rd_data = snap_ins[31:16];
      ADDR_CTRL:   rd_data[CTRL_EN_BIT] = en;
      ADDR_STATUS: begin
        rd_data[STAT_HALT_BIT]    = halted;
        rd_data[STAT_TIMEOUT_BIT] = timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rsp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_v) begin
            state <= RESP;
            rsp_q <= req_we ? 16'h0000 : rd_data;
          end
        end
        RESP: begin
          if (rsp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_rdy  = (state == IDLE);
  assign rsp_v    = (state == RESP);
  assign rsp_data = rsp_v ? rsp_q : 16'h0000;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the counter/register rules.
module tb_perf_counter_mmio;

  localparam int unsigned LIMIT = 10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        W_v = 1'b0;
  logic        isHalt = 1'b0;
  logic        req_v = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_addr = 3'd0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_rdy = 1'b1;
  logic        req_rdy;
  logic        rsp_v;
  logic [15:0] rsp_data;
  logic        halted;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  perf_counter_mmio #(.WDOG_LIMIT(LIMIT), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .W_v       (W_v),
    .isHalt    (isHalt),
    .req_v     (req_v),
    .req_rdy   (req_rdy),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_v     (rsp_v),
    .rsp_rdy   (rsp_rdy),
    .rsp_data  (rsp_data),
    .halted    (halted),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state advanced once per clock from the rules.
  typedef struct {
    int unsigned cyc;
    int unsigned ins;
    bit          en;
    bit          halt;
    bit          to;
    bit          busy;
    logic [15:0] snap_hi;
    int unsigned snap_ins;
    logic [15:0] rsp;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.cyc = 0; r.ins = 0; r.en = 1'b1; r.halt = 1'b0; r.to = 1'b0;
    r.busy = 1'b0; r.snap_hi = 16'h0; r.snap_ins = 0; r.rsp = 16'h0;
    return r;
  endfunction

  function automatic model_t model_step(model_t o);
    model_t n = o;
    bit act = o.en && !o.halt && !o.to;
    if (act) begin
      if (o.cyc != 32'hFFFF_FFFF) n.cyc = o.cyc + 1;
      if (W_v && o.ins != 32'hFFFF_FFFF) n.ins = o.ins + 1;
      if (isHalt) n.halt = 1'b1;
      if (o.cyc + 1 == LIMIT) n.to = 1'b1;
    end
    if (!o.busy) begin
      if (req_v) begin
        n.busy = 1'b1;
        n.rsp  = 16'h0;
        if (req_we) begin
          if (req_addr == 3'd4) begin
            if (req_wdata[1]) begin
              n.cyc = 0; n.ins = 0; n.halt = 1'b0; n.to = 1'b0;
              n.snap_hi = 16'h0; n.snap_ins = 0;
            end else begin
              n.en = req_wdata[0];
            end
          end
        end else begin
          case (req_addr)
            3'd0: begin
              n.rsp = o.cyc[15:0];
              n.snap_hi = o.cyc[31:16];
              n.snap_ins = o.ins;
            end
            3'd1: n.rsp = o.snap_hi;
            3'd2: n.rsp = o.snap_ins[15:0];
            3'd3: n.rsp = o.snap_ins[31:16];
            3'd4: n.rsp = {15'h0, o.en};
            3'd5: n.rsp = {14'h0, o.to, o.halt};
            default: n.rsp = 16'h0;
          endcase
        end
      end
    end else if (rsp_rdy) begin
      n.busy = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m);
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mon_rsp_v",    rsp_v,    m.busy);
      check("mon_req_rdy",  req_rdy,  !m.busy);
      check("mon_rsp_data", rsp_data, m.busy ? m.rsp : 16'h0);
      check("mon_halted",   halted,   m.halt);
      check("mon_timeout",  timeout,  m.to);
    end
  end

  task automatic xact(input bit we, input logic [2:0] addr, input logic [15:0] wd,
                      input int stall, output logic [15:0] rd);
    int n = 0;
    while (!req_rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy_wait", req_rdy, 1);
    req_v = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    rsp_rdy = (stall == 0);
    @(negedge clk);
    req_v = 1'b0; req_we = 1'b0;
    check("rsp_latency", rsp_v, 1);
    check("req_rdy_busy", req_rdy, 0);
    rd = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_v", rsp_v, 1);
      check("stall_rsp_data", rsp_data, rd);
      check("stall_req_rdy", req_rdy, 0);
    end
    rsp_rdy = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic [15:0] rd, v1, v2;
    int n;

    repeat (3) @(negedge clk);
    check("rst_req_rdy",  req_rdy,  1);
    check("rst_rsp_v",    rsp_v,    0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_halted",   halted,   0);
    check("rst_timeout",  timeout,  0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 100 cycles, W_v every other cycle
    for (int i = 0; i < 100; i++) begin
      W_v = (i % 2 == 0);
      @(negedge clk);
    end
    W_v = 1'b0;
    xact(1'b0, 3'd0, 16'h0, 0, rd); check("cyc_lo_100", rd, 100);
    xact(1'b0, 3'd1, 16'h0, 0, rd); check("cyc_hi_0",   rd, 0);
    xact(1'b0, 3'd2, 16'h0, 0, rd); check("ins_lo_50",  rd, 50);
    xact(1'b0, 3'd3, 16'h0, 0, rd); check("ins_hi_0",   rd, 0);
    xact(1'b0, 3'd6, 16'h0, 0, rd); check("addr6_zero", rd, 0);
    xact(1'b1, 3'd7, 16'hFFFF, 0, rd); check("write_rsp_zero", rd, 0);

    // halt on the 41st counted cycle after a clear
    xact(1'b1, 3'd4, 16'h0002, 0, rd);
    W_v = 1'b1;
    repeat (40) @(negedge clk);
    isHalt = 1'b1;
    @(negedge clk);
    isHalt = 1'b0; W_v = 1'b0;
    check("halt_flag", halted, 1);
    repeat (5) @(negedge clk);
    xact(1'b0, 3'd5, 16'h0, 0, rd); check("status_halt", rd, 16'h0001);
    xact(1'b0, 3'd0, 16'h0, 0, rd); check("halt_cyc",    rd, 41);
    xact(1'b0, 3'd2, 16'h0, 0, rd); check("halt_ins",    rd, 41);

    // clear-only write resumes counting with en still set
    xact(1'b1, 3'd4, 16'h0002, 0, rd);
    check("clr_halted", halted, 0);
    repeat (10) @(negedge clk);
    xact(1'b0, 3'd0, 16'h0, 0, rd); check("clr_resume_cyc", rd, 10);
    xact(1'b0, 3'd4, 16'h0, 0, rd); check("ctrl_en_kept",   rd, 16'h0001);

    // disable: cyc frozen
    xact(1'b1, 3'd4, 16'h0000, 0, rd);
    xact(1'b0, 3'd0, 16'h0, 0, v1);
    repeat (20) @(negedge clk);
    xact(1'b0, 3'd0, 16'h0, 0, v2); check("en0_frozen", v2, v1);
    xact(1'b0, 3'd4, 16'h0, 0, rd); check("ctrl_en_off", rd, 16'h0000);
    xact(1'b1, 3'd4, 16'h0001, 0, rd);

    // stalled response; counters keep running underneath
    xact(1'b0, 3'd0, 16'h0, 0, v1);
    xact(1'b0, 3'd2, 16'h0, 5, rd);
    xact(1'b0, 3'd0, 16'h0, 0, v2);
    check("stall_cnt_advance", v2 - v1, 9);

    // watchdog
    xact(1'b1, 3'd4, 16'h0002, 0, rd);
    n = 0;
    while (!timeout && n < 12000) begin
      W_v = 1'($urandom);
      @(negedge clk);
      n++;
    end
    W_v = 1'b0;
    check("wdog_cycles", n, LIMIT);
    check("wdog_flag", timeout, 1);
    repeat (10) @(negedge clk);
    xact(1'b0, 3'd0, 16'h0, 0, rd); check("wdog_cyc_hold", rd, LIMIT);
    xact(1'b0, 3'd1, 16'h0, 0, rd); check("wdog_cyc_hi",   rd, 0);
    xact(1'b0, 3'd5, 16'h0, 0, rd); check("status_to",     rd, 16'h0002);

    // halt coincident with the watchdog limit sets both flags
    xact(1'b1, 3'd4, 16'h0002, 0, rd);
    repeat (9999) @(negedge clk);
    isHalt = 1'b1;
    @(negedge clk);
    isHalt = 1'b0;
    check("both_halted",  halted,  1);
    check("both_timeout", timeout, 1);
    xact(1'b0, 3'd5, 16'h0, 0, rd); check("status_both", rd, 16'h0003);
    xact(1'b0, 3'd0, 16'h0, 0, rd); check("both_cyc",    rd, LIMIT);

    // randomized traffic against the model
    xact(1'b1, 3'd4, 16'h0002, 0, rd);
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          W_v    = 1'($urandom);
          isHalt = ($urandom_range(0, 199) == 0);
          @(negedge clk);
        end
        W_v = 1'b0; isHalt = 1'b0;
      end
      begin
        logic        rwe;
        logic [2:0]  ra;
        logic [15:0] rwd, rrd;
        for (int i = 0; i < 300; i++) begin
          rwe = ($urandom_range(0, 3) == 0);
          ra  = 3'($urandom);
          rwd = 16'($urandom);
          if (rwe && ra == 3'd4) rwd[0] = ($urandom_range(0, 3) != 0);
          xact(rwe, ra, rwd, $urandom_range(0, 3), rrd);
        end
      end
    join

    // reset while a response is pending
    @(negedge clk);
    req_v = 1'b1; req_we = 1'b0; req_addr = 3'd2; rsp_rdy = 1'b0;
    @(negedge clk);
    req_v = 1'b0;
    check("pre_rst_rsp_v", rsp_v, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_v",    rsp_v,    0);
    check("rst_mid_req_rdy",  req_rdy,  1);
    check("rst_mid_rsp_data", rsp_data, 0);
    check("rst_mid_halted",   halted,   0);
    @(negedge clk);
    rsp_rdy = 1'b1;
    rst_n = 1'b1;
    xact(1'b0, 3'd1, 16'h0, 0, rd); check("post_rst_cyc_hi", rd, 0);
    xact(1'b0, 3'd2, 16'h0, 0, rd); check("post_rst_ins_lo", rd, 0);
    xact(1'b0, 3'd3, 16'h0, 0, rd); check("post_rst_ins_hi", rd, 0);
    xact(1'b0, 3'd5, 16'h0, 0, rd); check("post_rst_status", rd, 0);
    xact(1'b0, 3'd4, 16'h0, 0, rd); check("post_rst_ctrl",   rd, 16'h0001);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
